axis_gate_shaper: RTL and testbench

- Sits directly downstream of the gate controller. Consumes its `dout` gate and 16-bit `level`, and applies a linear attack/release amplitude envelope to a signed sample stream, typically DDS output phased by `poff`.
- Removes hard on/off edges from gated RF pulses.
- Output: the envelope-scaled AXI4-Stream, plus the current envelope value for monitoring.

---
 rtl/gate_shaper_pkg.sv | 28 ++
 rtl/gate_shaper_ramp.sv | 130 +++++++++++++
 rtl/axis_gate_shaper.sv | 88 ++++++++
 tb/tb_axis_gate_shaper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_shaper_pkg.sv
// -----------------------------------------------------------------------------
// gate_shaper_pkg
// Shared definitions for the gate-driven attack/release envelope shaper.
//   state_t           : ramp FSM states (IDLE, RISE, HOLD, FALL)
//   ENV_WIDTH         : width of the envelope / level words
//   RAMP_BITS_DEFAULT : default log2 of the ramp length in aclk cycles
//   RAMP_MAX          : ramp length for the default RAMP_BITS
//   ramp_max()        : ramp length 2^bits for any legal RAMP_BITS (1..12)
// -----------------------------------------------------------------------------
package gate_shaper_pkg;

    localparam int ENV_WIDTH         = 16;
    localparam int RAMP_BITS_DEFAULT = 4;
    localparam int RAMP_MAX          = 32'sd1 << RAMP_BITS_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } state_t;

    // Ramp length in cycles for a given RAMP_BITS.
    function automatic int ramp_max(input int bits);
        return 32'sd1 << bits;
    endfunction

endpackage

// File: rtl/gate_shaper_ramp.sv
// -----------------------------------------------------------------------------
// gate_shaper_ramp
// Attack/release FSM plus ramp index k and envelope register.
//   aclk, aresetn : clock, synchronous active-low reset
//   gate          : gate request (high = pulse on)
//   level         : unsigned target amplitude
//   env           : registered envelope, (lvl_sel * k) >> RAMP_BITS
//   busy          : high whenever the FSM is not in IDLE
// Optional build macro GATE_SHAPER_LEVEL_TRACK_EN: when defined the envelope
// follows the live level input instead of the value latched on IDLE->RISE.
// -----------------------------------------------------------------------------
module gate_shaper_ramp
    import gate_shaper_pkg::*;
#(
    parameter int RAMP_BITS = RAMP_BITS_DEFAULT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 gate,
    input  logic [ENV_WIDTH-1:0] level,
    output logic [ENV_WIDTH-1:0] env,
    output logic                 busy
);

    localparam int KW = RAMP_BITS + 1;
    localparam int PW = ENV_WIDTH + KW;

    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_MAX  = KW'(ramp_max(RAMP_BITS));

    state_t                 state_r;
    state_t                 state_s;
    logic [KW-1:0]          k_r;
    logic [KW-1:0]          k_s;
    logic [ENV_WIDTH-1:0]   lvl_r;
    logic [ENV_WIDTH-1:0]   lvl_s;
    logic [ENV_WIDTH-1:0]   lvl_sel_s;
    logic [ENV_WIDTH-1:0]   env_r;
    logic [ENV_WIDTH-1:0]   env_next_s;
    logic [PW-1:0]          env_prod_s;
    logic                   busy_r;

`ifdef GATE_SHAPER_LEVEL_TRACK_EN
    assign lvl_sel_s = level;
`else
    assign lvl_sel_s = lvl_r;
`endif

    // Exact product; at k = 2^RAMP_BITS the shift returns lvl_sel unchanged.
    assign env_prod_s = {{KW{1'b0}}, lvl_sel_s} * {{ENV_WIDTH{1'b0}}, k_r};
    assign env_next_s = ENV_WIDTH'(env_prod_s >> RAMP_BITS);

    // Next-state, ramp index and level-latch logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        lvl_s   = lvl_r;
        case (state_r)
            IDLE: begin
                // Leaving IDLE counts as the first ramp step, so a full
                // rise takes exactly 2^RAMP_BITS cycles.
                if (gate) begin
                    state_s = RISE;
                    k_s     = K_ONE;
                    lvl_s   = level;
                end else begin
                    state_s = IDLE;
                    k_s     = K_ZERO;
                end
            end
            RISE: begin
                // Release starts from the current amplitude: k is kept.
                if (!gate) begin
                    state_s = FALL;
                end else if (k_r >= (K_MAX - K_ONE)) begin
                    state_s = HOLD;
                    k_s     = K_MAX;
                end else begin
                    k_s     = k_r + K_ONE;
                end
            end
            HOLD: begin
                // First fall step happens on the cycle the gate drops.
                if (!gate) begin
                    state_s = FALL;
                    k_s     = K_MAX - K_ONE;
                end else begin
                    k_s     = K_MAX;
                end
            end
            FALL: begin
                // Re-entry to RISE keeps k and does not re-latch the level.
                if (gate) begin
                    state_s = RISE;
                end else if (k_r <= K_ONE) begin
                    state_s = IDLE;
                    k_s     = K_ZERO;
                end else begin
                    k_s     = k_r - K_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                k_s     = K_ZERO;
            end
        endcase
    end

    // State, ramp index, latched level, envelope and busy registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= IDLE;
            k_r     <= K_ZERO;
            lvl_r   <= {ENV_WIDTH{1'b0}};
            env_r   <= {ENV_WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            lvl_r   <= lvl_s;
            env_r   <= env_next_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign env  = env_r;
    assign busy = busy_r;

endmodule

// File: rtl/axis_gate_shaper.sv
// -----------------------------------------------------------------------------
// axis_gate_shaper
// Applies a linear attack/release envelope, driven by a gate, to a signed
// AXI4-Stream sample flow.
//   aclk, aresetn        : clock, synchronous active-low reset
//   gate, level          : gate request and 16-bit unsigned target amplitude
//   s_axis_*             : signed input samples (tdata, tvalid, tready)
//   m_axis_*             : envelope-scaled output samples, 1-cycle latency
//   env                  : current envelope value (monitoring)
//   busy                 : envelope FSM not in IDLE
// Optional build macro GATE_SHAPER_LEVEL_TRACK_EN (see gate_shaper_ramp).
// -----------------------------------------------------------------------------
module axis_gate_shaper
    import gate_shaper_pkg::*;
#(
    parameter int RAMP_BITS        = RAMP_BITS_DEFAULT,
    parameter int AXIS_TDATA_WIDTH = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        gate,
    input  logic [ENV_WIDTH-1:0]        level,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic [ENV_WIDTH-1:0]        env,
    output logic                        busy
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int SW = W + ENV_WIDTH + 1;

    logic [ENV_WIDTH-1:0]  env_s;
    logic                  busy_s;
    logic                  s_ready_s;
    logic                  s_xfer_s;
    logic signed [SW-1:0]  scale_prod_s;
    logic [W-1:0]          scaled_s;
    logic [W-1:0]          m_tdata_r;
    logic                  m_tvalid_r;

    gate_shaper_ramp #(
        .RAMP_BITS (RAMP_BITS)
    ) u_ramp (
        .aclk    (aclk),
        .aresetn (aresetn),
        .gate    (gate),
        .level   (level),
        .env     (env_s),
        .busy    (busy_s)
    );

    assign s_ready_s = ~m_tvalid_r | m_axis_tready;
    assign s_xfer_s  = s_axis_tvalid & s_ready_s;

    // Envelope is zero-extended to a positive 17-bit signed factor; |env| < 2^16
    // so the >>> 16 result always fits back into W bits.
    assign scale_prod_s = $signed({{(ENV_WIDTH + 1){s_axis_tdata[W-1]}}, s_axis_tdata})
                        * $signed({{W{1'b0}}, 1'b0, env_s});
    assign scaled_s     = W'(scale_prod_s >>> ENV_WIDTH);

    // Single output register: load on transfer, drain on ready, hold on stall.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_tdata_r  <= {W{1'b0}};
            m_tvalid_r <= 1'b0;
        end else if (s_xfer_s) begin
            m_tdata_r  <= scaled_s;
            m_tvalid_r <= 1'b1;
        end else if (m_axis_tready) begin
            m_tdata_r  <= m_tdata_r;
            m_tvalid_r <= 1'b0;
        end else begin
            m_tdata_r  <= m_tdata_r;
            m_tvalid_r <= m_tvalid_r;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign env           = env_s;
    assign busy          = busy_s;

endmodule

// File: tb/tb_axis_gate_shaper.sv
// -----------------------------------------------------------------------------
// tb_axis_gate_shaper
// Directed bench for axis_gate_shaper with RAMP_BITS=4, 16-bit samples.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_axis_gate_shaper;

    localparam int W = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          gate;
    logic [15:0]   level;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic [15:0]   env;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_gate_shaper #(
        .RAMP_BITS        (4),
        .AXIS_TDATA_WIDTH (W)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .gate          (gate),
        .level         (level),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .env           (env),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] exp_v;
        logic [31:0] peak;
        logic [15:0] exp_lvl;

        aresetn       = 1'b0;
        gate          = 1'b0;
        level         = 16'h0000;
        s_axis_tdata  = 16'h0000;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        step(2);
        check_eq("rst_env",    32'(env),           32'h0);
        check_eq("rst_busy",   32'(busy),          32'h0);
        check_eq("rst_mvalid", 32'(m_axis_tvalid), 32'h0);
        check_eq("rst_mdata",  32'(m_axis_tdata),  32'h0);
        check_eq("rst_sready", 32'(s_axis_tready), 32'h1);
        aresetn = 1'b1;
        step(1);

        // Full pulse: 0x800 per cycle up to 0x8000, hold, down to 0.
        level         = 16'h8000;
        gate          = 1'b1;
        s_axis_tdata  = 16'h7FFF;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            step(1);
            check_eq("rise_env", 32'(env), 32'(n * 32'h800));
            if (n >= 1) begin
                exp_v = (32'h7FFF * ((n - 1) * 32'h800)) >> 16;
                check_eq("rise_mdata", 32'(m_axis_tdata), exp_v);
            end
        end
        check_eq("rise_busy", 32'(busy), 32'h1);
        step(23);
        check_eq("hold_env",   32'(env),          32'h8000);
        check_eq("peak_mdata", 32'(m_axis_tdata), 32'h3FFF);
        gate = 1'b0;
        for (int m = 1; m <= 17; m++) begin
            step(1);
            check_eq("fall_env",  32'(env),  32'((17 - m) * 32'h800));
            check_eq("fall_busy", 32'(busy), (m < 16) ? 32'h1 : 32'h0);
        end
        check_eq("fall_mdata", 32'(m_axis_tdata), 32'h3FF);

        // Short gate: triangular envelope peaking at 0x2800.
        gate = 1'b1;
        step(5);
        gate = 1'b0;
        peak = 32'h0;
        for (int i = 0; i < 13; i++) begin
            step(1);
            if (32'(env) > peak) peak = 32'(env);
            if (i == 0) check_eq("short_turn", 32'(env), 32'h2800);
            if (i == 2) check_eq("short_down", 32'(env), 32'h2000);
        end
        check_eq("short_peak", peak,        32'h2800);
        check_eq("short_busy", 32'(busy),   32'h0);
        check_eq("short_env0", 32'(env),    32'h0);

        // Re-trigger: drop at full scale, re-rise at k=8.
        gate = 1'b1;
        step(20);
        check_eq("retrig_hold", 32'(env), 32'h8000);
        gate = 1'b0;
        step(8);
        check_eq("retrig_fall", 32'(env), 32'h4800);
        gate = 1'b1;
        step(1);
        check_eq("retrig_rev0", 32'(env), 32'h4000);
        step(1);
        check_eq("retrig_rev1", 32'(env), 32'h4000);
        step(1);
        check_eq("retrig_up",   32'(env), 32'h4800);
        step(10);
        check_eq("retrig_top",  32'(env),  32'h8000);
        check_eq("retrig_busy", 32'(busy), 32'h1);
        gate = 1'b0;
        step(18);
        check_eq("retrig_idle", 32'(busy), 32'h0);
        check_eq("retrig_env0", 32'(env),  32'h0);

        // Level change while holding.
`ifdef GATE_SHAPER_LEVEL_TRACK_EN
        exp_lvl = 16'h4000;
`else
        exp_lvl = 16'h8000;
`endif
        gate = 1'b1;
        step(20);
        check_eq("lvl_hold", 32'(env), 32'h8000);
        level = 16'h4000;
        step(1);
        check_eq("lvl_chg1", 32'(env), 32'(exp_lvl));
        step(1);
        check_eq("lvl_chg2", 32'(env), 32'(exp_lvl));
        gate  = 1'b0;
        level = 16'h8000;
        step(18);
        check_eq("lvl_idle", 32'(busy), 32'h0);

        // Backpressure at env = 0x8000.
        gate = 1'b1;
        step(20);
        s_axis_tdata = 16'h1000;
        step(1);
        check_eq("bp_first",  32'(m_axis_tdata),  32'h0800);
        check_eq("bp_valid",  32'(m_axis_tvalid), 32'h1);
        m_axis_tready = 1'b0;
        s_axis_tdata  = 16'h2000;
        #1;
        check_eq("bp_sready0", 32'(s_axis_tready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("bp_hold_data",  32'(m_axis_tdata),  32'h0800);
            check_eq("bp_hold_valid", 32'(m_axis_tvalid), 32'h1);
            check_eq("bp_hold_ready", 32'(s_axis_tready), 32'h0);
        end
        m_axis_tready = 1'b1;
        #1;
        check_eq("bp_sready1", 32'(s_axis_tready), 32'h1);
        step(1);
        check_eq("bp_next", 32'(m_axis_tdata), 32'h1000);
        s_axis_tdata = 16'hC000;
        step(1);
        check_eq("bp_neg",  32'(m_axis_tdata), 32'hE000);
        s_axis_tdata = 16'hFFFF;
        step(1);
        check_eq("bp_neg1", 32'(m_axis_tdata), 32'hFFFF);
        s_axis_tvalid = 1'b0;
        step(1);
        check_eq("bp_drain", 32'(m_axis_tvalid), 32'h0);
        gate = 1'b0;
        step(18);
        check_eq("bp_idle", 32'(busy), 32'h0);

        // Reset mid-rise.
        s_axis_tdata  = 16'h7FFF;
        s_axis_tvalid = 1'b1;
        gate          = 1'b1;
        step(6);
        check_eq("mid_busy",   32'(busy),          32'h1);
        check_eq("mid_mvalid", 32'(m_axis_tvalid), 32'h1);
        aresetn = 1'b0;
        step(1);
        check_eq("mrst_env",    32'(env),           32'h0);
        check_eq("mrst_busy",   32'(busy),          32'h0);
        check_eq("mrst_mvalid", 32'(m_axis_tvalid), 32'h0);
        gate          = 1'b0;
        s_axis_tvalid = 1'b0;
        aresetn       = 1'b1;
        step(2);
        check_eq("post_busy", 32'(busy), 32'h0);
        check_eq("post_env",  32'(env),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
